// File: rtl/apb_master.sv
// APB requester: turns one command into an APB transfer, one at a time.
// Define APB_TIMEOUT_EN to bound ACCESS wait states by TIMEOUT cycles.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_d;

  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt, cnt_d;
`endif

  assign cmd_ready = (state == IDLE);

  always_comb begin
    state_d     = state;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          if (!pwrite) rsp_rdata_d = prdata;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          cnt_d = cnt + 1'b1;
          // this wait cycle brings the count to TIMEOUT
          if (cnt == CLAST) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = IDLE;
          end
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: latency, waits, errors,
// back-to-back commands, reset abort and optional timeout.
module tb_apb_master;

  logic       pclk = 1'b0;
  logic       prst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [7:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  logic       psel;
  logic       penable;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b0;
  logic       pslverr = 1'b0;

  int total = 0;
  int bad = 0;

  apb_master #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(4)
  ) dut (
    .pclk     (pclk),
    .prst     (prst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 pclk = ~pclk;

  // {psel, penable, rsp_valid}
  logic [2:0] ctl;
  assign ctl = {psel, penable, rsp_valid};

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    #1 prst = 1'b1;
    #2;
    total++;
    if ({cmd_ready, ctl, pwrite, rsp_err, paddr, pwdata, rsp_rdata}
        !== {1'b1, 5'b0, 24'h0}) begin
      bad++;
      $display("FAIL rst_async got=%h exp=%h",
        {cmd_ready, ctl, pwrite, rsp_err, paddr, pwdata, rsp_rdata},
        {1'b1, 5'b0, 24'h0});
    end
    cmd_valid = 1'b1;
    cmd_addr  = 8'hC3;
    tick();
    tick();
    total++;
    if ({cmd_ready, ctl, paddr} !== {1'b1, 3'b000, 8'h00}) begin
      bad++;
      $display("FAIL rst_held got=%h exp=%h",
        {cmd_ready, ctl, paddr}, {1'b1, 3'b000, 8'h00});
    end
    cmd_valid = 1'b0;
    prst = 1'b0;
    tick();
    total++;
    if ({cmd_ready, ctl} !== 4'b1000) begin
      bad++;
      $display("FAIL rst_release got=%b exp=%b", {cmd_ready, ctl}, 4'b1000);
    end
  endtask

  task automatic test_write();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h10;
    cmd_wdata = 8'hA5;
    pready    = 1'b1;
    pslverr   = 1'b1;
    prdata    = 8'hEE;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_ready got=%b exp=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({cmd_ready, ctl, pwrite, paddr, pwdata}
        !== {1'b0, 3'b100, 1'b1, 8'h10, 8'hA5}) begin
      bad++;
      $display("FAIL wr_setup got=%h exp=%h",
        {cmd_ready, ctl, pwrite, paddr, pwdata},
        {1'b0, 3'b100, 1'b1, 8'h10, 8'hA5});
    end
    pslverr = 1'b0;
    tick();
    total++;
    if ({ctl, pwrite, paddr, pwdata} !== {3'b110, 1'b1, 8'h10, 8'hA5}) begin
      bad++;
      $display("FAIL wr_access got=%h exp=%h",
        {ctl, pwrite, paddr, pwdata}, {3'b110, 1'b1, 8'h10, 8'hA5});
    end
    tick();
    total++;
    if ({ctl, rsp_err, rsp_rdata} !== {3'b001, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL wr_rsp got=%h exp=%h",
        {ctl, rsp_err, rsp_rdata}, {3'b001, 1'b0, 8'h00});
    end
    pready = 1'b0;
    tick();
    total++;
    if (ctl !== 3'b000) begin
      bad++;
      $display("FAIL wr_after got=%b exp=000", ctl);
    end
  endtask

  task automatic test_read_wait();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h10;
    cmd_wdata = 8'h00;
    pready    = 1'b0;
    prdata    = 8'h00;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({ctl, pwrite, paddr} !== {3'b100, 1'b0, 8'h10}) begin
      bad++;
      $display("FAIL rd_setup got=%h exp=%h",
        {ctl, pwrite, paddr}, {3'b100, 1'b0, 8'h10});
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({ctl, paddr} !== {3'b110, 8'h10}) begin
        bad++;
        $display("FAIL rd_wait%0d got=%h exp=%h",
          i, {ctl, paddr}, {3'b110, 8'h10});
      end
      tick();
    end
    total++;
    if ({ctl, paddr} !== {3'b110, 8'h10}) begin
      bad++;
      $display("FAIL rd_last got=%h exp=%h", {ctl, paddr}, {3'b110, 8'h10});
    end
    pready = 1'b1;
    prdata = 8'hA5;
    tick();
    total++;
    if ({ctl, rsp_err, rsp_rdata} !== {3'b001, 1'b0, 8'hA5}) begin
      bad++;
      $display("FAIL rd_rsp got=%h exp=%h",
        {ctl, rsp_err, rsp_rdata}, {3'b001, 1'b0, 8'hA5});
    end
    pready = 1'b0;
    prdata = 8'h00;
    tick();
    total++;
    if ({ctl, rsp_rdata} !== {3'b000, 8'hA5}) begin
      bad++;
      $display("FAIL rd_hold got=%h exp=%h",
        {ctl, rsp_rdata}, {3'b000, 8'hA5});
    end
  endtask

  task automatic test_slverr();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h80;
    pready    = 1'b1;
    pslverr   = 1'b1;
    prdata    = 8'h3C;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    total++;
    if ({ctl, rsp_err, rsp_rdata} !== {3'b001, 1'b1, 8'h3C}) begin
      bad++;
      $display("FAIL err_rsp got=%h exp=%h",
        {ctl, rsp_err, rsp_rdata}, {3'b001, 1'b1, 8'h3C});
    end
    pslverr = 1'b0;
    tick();
    total++;
    if ({ctl, rsp_err} !== {3'b000, 1'b1}) begin
      bad++;
      $display("FAIL err_pulse got=%b exp=%b", {ctl, rsp_err}, 4'b0001);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h20;
    cmd_wdata = 8'h11;
    pready    = 1'b1;
    pslverr   = 1'b0;
    prdata    = 8'h99;
    tick();
    total++;
    if ({ctl, paddr, pwdata} !== {3'b100, 8'h20, 8'h11}) begin
      bad++;
      $display("FAIL b2b_setup1 got=%h exp=%h",
        {ctl, paddr, pwdata}, {3'b100, 8'h20, 8'h11});
    end
    tick();
    total++;
    if ({cmd_ready, ctl, paddr} !== {1'b0, 3'b110, 8'h20}) begin
      bad++;
      $display("FAIL b2b_access1 got=%h exp=%h",
        {cmd_ready, ctl, paddr}, {1'b0, 3'b110, 8'h20});
    end
    tick();
    total++;
    if ({cmd_ready, ctl, rsp_err, rsp_rdata}
        !== {1'b1, 3'b001, 1'b0, 8'h3C}) begin
      bad++;
      $display("FAIL b2b_rsp1 got=%h exp=%h",
        {cmd_ready, ctl, rsp_err, rsp_rdata},
        {1'b1, 3'b001, 1'b0, 8'h3C});
    end
    cmd_write = 1'b0;
    cmd_addr  = 8'h30;
    prdata    = 8'h5A;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({ctl, pwrite, paddr} !== {3'b100, 1'b0, 8'h30}) begin
      bad++;
      $display("FAIL b2b_setup2 got=%h exp=%h",
        {ctl, pwrite, paddr}, {3'b100, 1'b0, 8'h30});
    end
    tick();
    tick();
    total++;
    if ({ctl, rsp_err, rsp_rdata} !== {3'b001, 1'b0, 8'h5A}) begin
      bad++;
      $display("FAIL b2b_rsp2 got=%h exp=%h",
        {ctl, rsp_err, rsp_rdata}, {3'b001, 1'b0, 8'h5A});
    end
    pready = 1'b0;
    tick();
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h66;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ctl !== 3'b110) begin
        bad++;
        $display("FAIL to_wait%0d got=%b exp=110", i, ctl);
      end
      tick();
    end
    total++;
    if ({ctl, rsp_err, rsp_rdata} !== {3'b001, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL to_rsp got=%h exp=%h",
        {ctl, rsp_err, rsp_rdata}, {3'b001, 1'b1, 8'h00});
    end
    tick();
  endtask
`endif

  task automatic test_reset_abort();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h44;
    pready    = 1'b0;
    pslverr   = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    total++;
    if (ctl !== 3'b110) begin
      bad++;
      $display("FAIL ab_wait2 got=%b exp=110", ctl);
    end
    #2 prst = 1'b1;
    #1;
    total++;
    if ({cmd_ready, ctl, paddr} !== {1'b1, 3'b000, 8'h00}) begin
      bad++;
      $display("FAIL ab_async got=%h exp=%h",
        {cmd_ready, ctl, paddr}, {1'b1, 3'b000, 8'h00});
    end
    tick();
    prst = 1'b0;
    tick();
    total++;
    if ({cmd_ready, ctl} !== 4'b1000) begin
      bad++;
      $display("FAIL ab_norsp got=%b exp=1000", {cmd_ready, ctl});
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h55;
    cmd_wdata = 8'h77;
    pready    = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({ctl, paddr, pwdata} !== {3'b100, 8'h55, 8'h77}) begin
      bad++;
      $display("FAIL ab_setup got=%h exp=%h",
        {ctl, paddr, pwdata}, {3'b100, 8'h55, 8'h77});
    end
    tick();
    total++;
    if (ctl !== 3'b110) begin
      bad++;
      $display("FAIL ab_access got=%b exp=110", ctl);
    end
    tick();
    total++;
    if ({ctl, rsp_err, rsp_rdata} !== {3'b001, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL ab_rsp got=%h exp=%h",
        {ctl, rsp_err, rsp_rdata}, {3'b001, 1'b0, 8'h00});
    end
    pready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
